aemb_fsl_slave: RTL and testbench

// - Responder end of the AEMB FSL wishbone: serves core GET/PUT on one channel.
// - PUT words go into a TX FIFO that drains to an external valid/ready stream.
// - GET words come from an RX FIFO that fills from an external valid/ready stream.
// - Blocking accesses hold off ack until the FIFO allows; non-blocking accesses ack at once and flag failure.

---
 rtl/aemb_fsl_slave_if.sv | 22 ++
 rtl/aemb_fsl_slave.sv | 180 ++++++++++++++++++
 tb/tb_aemb_fsl_slave.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aemb_fsl_slave_if.sv
// Core-side FSL bus between the AEMB core (master) and an FSL responder (slave).
// adr carries fsl address bits [6:2]; tag[1] = control word, tag[0] = non-blocking.
interface aemb_fsl_slave_if;
    logic        stb;
    logic        wre;
    logic [4:0]  adr;
    logic [1:0]  tag;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output stb, wre, adr, tag, wdat,
        input  rdat, ack, err
    );

    modport slave (
        input  stb, wre, adr, tag, wdat,
        output rdat, ack, err
    );
endinterface

// File: rtl/aemb_fsl_slave.sv
// FSL responder: core PUT feeds a TX FIFO drained by a valid/ready stream, GET reads an RX FIFO.
// Define AEMB_FSL_TIMEOUT_EN to make blocking accesses fail after TMO cycles in SERVE.
module aemb_fsl_slave #(
    parameter logic [4:0] CHAN = 5'd0,
    parameter int         AW   = 3,
    parameter int         TMO  = 255
) (
    input  logic             gclk,
    input  logic             grst,
    aemb_fsl_slave_if.slave  fsl,
    output logic [31:0]      tx_dat_o,
    output logic             tx_ctl_o,
    output logic             tx_vld_o,
    input  logic             tx_rdy_i,
    input  logic [31:0]      rx_dat_i,
    input  logic             rx_ctl_i,
    input  logic             rx_vld_i,
    output logic             rx_rdy_o
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] FULL  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [32:0]   tx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr;
    logic [AW:0]   tx_cnt;
    logic [32:0]   rx_mem [DEPTH];
    logic [AW-1:0] rx_wptr, rx_rptr;
    logic [AW:0]   rx_cnt;
    logic [32:0]   rx_head;

    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          done, done_err;
    logic [31:0]   done_dat;
    logic          tmo_exp;

    logic          ack_q, err_q;
    logic [31:0]   dat_q;

    assign tx_vld_o              = (tx_cnt != '0);
    assign tx_pop                = tx_vld_o & tx_rdy_i;
    assign {tx_ctl_o, tx_dat_o}  = tx_mem[tx_rptr];

    assign rx_rdy_o = (rx_cnt != FULL);
    assign rx_push  = rx_vld_i & rx_rdy_o;
    assign rx_head  = rx_mem[rx_rptr];

    assign fsl.ack  = ack_q;
    assign fsl.err  = err_q;
    assign fsl.rdat = dat_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d  = state_q;
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        done     = 1'b0;
        done_err = 1'b0;
        done_dat = '0;
        unique case (state_q)
            IDLE: begin
                if (fsl.stb && (fsl.adr == CHAN)) state_d = SERVE;
            end
            SERVE: begin
                // Full/empty come from the counts at the start of the cycle, so a
                // same-cycle stream pop/push never frees room for the core.
                if (!fsl.stb) begin
                    state_d = IDLE;
                end else if (fsl.wre) begin
                    if (tx_cnt != FULL) begin
                        tx_push = 1'b1;
                        done    = 1'b1;
                    end else if (fsl.tag[0] || tmo_exp) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end
                end else begin
                    if (rx_cnt != '0) begin
                        rx_pop   = 1'b1;
                        done     = 1'b1;
                        done_dat = rx_head[31:0];
                        done_err = (rx_head[32] != fsl.tag[1]);
                    end else if (fsl.tag[0] || tmo_exp) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                    end
                end
                if (done) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= done;
            err_q   <= done & done_err;
            dat_q   <= done_dat;
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_cnt  <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the counts make stale entries unreachable.
    always_ff @(posedge gclk) begin
        if (tx_push) tx_mem[tx_wptr] <= {fsl.tag[1], fsl.wdat};
        if (rx_push) rx_mem[rx_wptr] <= {rx_ctl_i, rx_dat_i};
    end

`ifdef AEMB_FSL_TIMEOUT_EN
    localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge gclk) begin
        if (grst) begin
            tmo_cnt <= '0;
        end else if (state_q == IDLE && state_d == SERVE) begin
            tmo_cnt <= TW'(TMO);
        end else if (state_q == SERVE && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign tmo_exp = (tmo_cnt == '0);
`else
    // Without the timeout a blocking access waits for the FIFO indefinitely.
    logic unused_tmo;
    assign unused_tmo = ^TMO;
    assign tmo_exp    = 1'b0;
`endif

endmodule

// File: tb/tb_aemb_fsl_slave.sv
// Self-checking bench for aemb_fsl_slave: vector table of single accesses, TX scoreboard,
// and hand-written sequences for back-pressure, channel filter, abort, reset and timeout.
module tb_aemb_fsl_slave;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int TMO   = 4;

    logic        gclk = 1'b0;
    logic        grst;
    logic [31:0] tx_dat_o;
    logic        tx_ctl_o, tx_vld_o, tx_rdy_i;
    logic [31:0] rx_dat_i;
    logic        rx_ctl_i, rx_vld_i, rx_rdy_o;

    always #5 gclk = ~gclk;

    aemb_fsl_slave_if fsl ();

    aemb_fsl_slave #(.CHAN(5'd0), .AW(AW), .TMO(TMO)) dut (
        .gclk     (gclk),
        .grst     (grst),
        .fsl      (fsl),
        .tx_dat_o (tx_dat_o),
        .tx_ctl_o (tx_ctl_o),
        .tx_vld_o (tx_vld_o),
        .tx_rdy_i (tx_rdy_i),
        .rx_dat_i (rx_dat_i),
        .rx_ctl_i (rx_ctl_i),
        .rx_vld_i (rx_vld_i),
        .rx_rdy_o (rx_rdy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard of {ctl,data} words expected on the TX stream, in order.
    logic [32:0] tx_exp [$];

    always begin
        @(negedge gclk);
        #1;
        if (grst === 1'b0 && tx_vld_o && tx_rdy_i) begin
            logic [32:0] w;
            check("tx_pop_expected", {31'b0, tx_exp.size() != 0}, 32'd1);
            if (tx_exp.size() != 0) begin
                w = tx_exp.pop_front();
                check("tx_dat", tx_dat_o, w[31:0]);
                check("tx_ctl", {31'b0, tx_ctl_o}, {31'b0, w[32]});
            end
        end
    end

    task automatic start(input bit wre, input bit [1:0] tag, input bit [4:0] adr, input bit [31:0] dat);
        @(negedge gclk);
        fsl.stb  = 1'b1;
        fsl.wre  = wre;
        fsl.tag  = tag;
        fsl.adr  = adr;
        fsl.wdat = dat;
    endtask

    task automatic wait_ack(input int budget, input bit hold, output bit got, output int lat,
                            output logic [31:0] d, output logic e);
        got = 1'b0;
        lat = 0;
        d   = '0;
        e   = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge gclk);
            if (fsl.ack === 1'b1) begin
                got = 1'b1;
                lat = i;
                d   = fsl.rdat;
                e   = fsl.err;
                if (!hold) fsl.stb = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_cleared(input string name);
        @(negedge gclk);
        check({name, "_ack_low"}, {30'b0, fsl.ack, fsl.err}, 32'd0);
        check({name, "_dat_low"}, fsl.rdat, 32'd0);
    endtask

    task automatic rx_push(input bit ctl, input bit [31:0] dat, output bit ok);
        @(negedge gclk);
        rx_vld_i = 1'b1;
        rx_ctl_i = ctl;
        rx_dat_i = dat;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rx_rdy_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge gclk);
        end
        @(negedge gclk);
        rx_vld_i = 1'b0;
    endtask

    typedef struct {
        bit        wre;
        bit [1:0]  tag;
        bit [31:0] dat;
        bit        pre;
        bit        pre_ctl;
        bit [31:0] pre_dat;
        bit        exp_err;
        bit [31:0] exp_dat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got, ok;
        int          lat;
        logic [31:0] d;
        logic        e;
        bit          seen;

        //           wre  tag    dat           pre ctl pre_dat        err exp_dat
        vecs[0] = '{1'b1, 2'b00, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b1, 2'b10, 32'h00000001, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b1, 2'b01, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[3] = '{1'b0, 2'b01, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h0};
        vecs[4] = '{1'b0, 2'b00, 32'h0,        1'b1, 1'b1, 32'h12345678, 1'b1, 32'h12345678};
        vecs[5] = '{1'b0, 2'b10, 32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 2'b00, 32'h0,        1'b1, 1'b0, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE};
        vecs[7] = '{1'b0, 2'b11, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h0};
        vecs[8] = '{1'b0, 2'b01, 32'h0,        1'b1, 1'b0, 32'h55AA55AA, 1'b0, 32'h55AA55AA};
        vecs[9] = '{1'b0, 2'b10, 32'h0,        1'b1, 1'b0, 32'h600DF00D, 1'b1, 32'h600DF00D};

        grst     = 1'b1;
        fsl.stb  = 1'b0;
        fsl.wre  = 1'b0;
        fsl.adr  = 5'd0;
        fsl.tag  = 2'b00;
        fsl.wdat = '0;
        tx_rdy_i = 1'b1;
        rx_vld_i = 1'b0;
        rx_ctl_i = 1'b0;
        rx_dat_i = '0;
        repeat (3) @(negedge gclk);
        check("rst_ack_err", {30'b0, fsl.ack, fsl.err}, 32'd0);
        check("rst_dat", fsl.rdat, 32'd0);
        check("rst_tx_vld", {31'b0, tx_vld_o}, 32'd0);
        check("rst_rx_rdy", {31'b0, rx_rdy_o}, 32'd1);
        grst = 1'b0;

        // Single accesses from the vector table, stream sink always ready.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].pre) begin
                rx_push(vecs[i].pre_ctl, vecs[i].pre_dat, ok);
                check($sformatf("v%0d_rx_push", i), {31'b0, ok}, 32'd1);
            end
            if (vecs[i].wre && !vecs[i].exp_err) tx_exp.push_back({vecs[i].tag[1], vecs[i].dat});
            start(vecs[i].wre, vecs[i].tag, 5'd0, vecs[i].dat);
            wait_ack(6, 1'b0, got, lat, d, e);
            check($sformatf("v%0d_ack", i), {31'b0, got}, 32'd1);
            check($sformatf("v%0d_lat", i), lat, 32'd2);
            check($sformatf("v%0d_dat", i), d, vecs[i].exp_dat);
            check($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            check_cleared($sformatf("v%0d", i));
        end
        repeat (2) @(negedge gclk);
        check("v_tx_drained", tx_exp.size(), 32'd0);

        // Fill TX with the sink stalled, block the ninth PUT, then release the sink.
        tx_rdy_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tx_exp.push_back({i[0], 32'h1000 + i});
            start(1'b1, {i[0], 1'b0}, 5'd0, 32'h1000 + i);
            wait_ack(6, 1'b0, got, lat, d, e);
            check($sformatf("fill%0d_ack", i), {30'b0, got, e}, 32'd2);
        end
        check("fill_tx_vld", {31'b0, tx_vld_o}, 32'd1);
        tx_exp.push_back({1'b0, 32'h2000});
        start(1'b1, 2'b00, 5'd0, 32'h2000);
        wait_ack(3, 1'b0, got, lat, d, e);
        check("full_put_blocked", {31'b0, got}, 32'd0);
        tx_rdy_i = 1'b1;
        wait_ack(20, 1'b0, got, lat, d, e);
        check("full_put_released", {30'b0, got, e}, 32'd2);
        for (int i = 0; i < 30 && tx_vld_o; i++) @(negedge gclk);
        check("fill_drained_vld", {31'b0, tx_vld_o}, 32'd0);
        check("fill_drained_sb", tx_exp.size(), 32'd0);

        // Strobe still high during DONE must not start a second access.
        tx_exp.push_back({1'b0, 32'h3000});
        start(1'b1, 2'b00, 5'd0, 32'h3000);
        wait_ack(6, 1'b1, got, lat, d, e);
        check("done_hold_ack", {31'b0, got}, 32'd1);
        @(negedge gclk);
        fsl.stb = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge gclk);
            seen |= fsl.ack;
        end
        check("done_hold_no_reack", {31'b0, seen}, 32'd0);
        check("done_hold_sb", tx_exp.size(), 32'd0);

        // Fill RX to full, then drain it through GETs in order.
        for (int i = 0; i < DEPTH; i++) begin
            rx_push(i[0], 32'h4000 + i, ok);
            check($sformatf("rxfill%0d_push", i), {31'b0, ok}, 32'd1);
        end
        check("rx_full_rdy", {31'b0, rx_rdy_o}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            start(1'b0, 2'b00, 5'd0, 32'h0);
            wait_ack(6, 1'b0, got, lat, d, e);
            check($sformatf("rxget%0d_ack", i), {31'b0, got}, 32'd1);
            check($sformatf("rxget%0d_dat", i), d, 32'h4000 + i);
            check($sformatf("rxget%0d_err", i), {31'b0, e}, {31'b0, i[0]});
        end
        check("rx_drained_rdy", {31'b0, rx_rdy_o}, 32'd1);

        // Another channel number is ignored even for a non-blocking access.
        start(1'b0, 2'b01, 5'd1, 32'h0);
        wait_ack(6, 1'b0, got, lat, d, e);
        check("other_chan_noack", {31'b0, got}, 32'd0);
        fsl.stb = 1'b0;
        @(negedge gclk);

        // Strobe dropped in SERVE aborts; the next GET sees only the new word.
        start(1'b0, 2'b00, 5'd0, 32'h0);
        @(negedge gclk);
        fsl.stb = 1'b0;
        wait_ack(4, 1'b0, got, lat, d, e);
        check("abort_noack", {31'b0, got}, 32'd0);
        rx_push(1'b0, 32'h00000077, ok);
        start(1'b0, 2'b00, 5'd0, 32'h0);
        wait_ack(6, 1'b0, got, lat, d, e);
        check("after_abort_dat", d, 32'h00000077);
        check("after_abort_lat", lat, 32'd2);

        // Reset during a blocked GET, with a word parked in TX.
        tx_rdy_i = 1'b0;
        start(1'b1, 2'b00, 5'd0, 32'h5000);
        wait_ack(6, 1'b0, got, lat, d, e);
        check("pre_rst_put", {31'b0, got}, 32'd1);
        start(1'b0, 2'b00, 5'd0, 32'h0);
        wait_ack(2, 1'b0, got, lat, d, e);
        check("pre_rst_get_blocked", {31'b0, got}, 32'd0);
        grst    = 1'b1;
        fsl.stb = 1'b0;
        seen    = 1'b0;
        repeat (2) begin
            @(negedge gclk);
            seen |= fsl.ack;
        end
        grst = 1'b0;
        @(negedge gclk);
        seen |= fsl.ack;
        check("rst_mid_noack", {31'b0, seen}, 32'd0);
        check("rst_mid_tx_empty", {31'b0, tx_vld_o}, 32'd0);
        check("rst_mid_rx_rdy", {31'b0, rx_rdy_o}, 32'd1);
        tx_rdy_i = 1'b1;
        start(1'b0, 2'b01, 5'd0, 32'h0);
        wait_ack(6, 1'b0, got, lat, d, e);
        check("rst_mid_nget_lat", lat, 32'd2);
        check("rst_mid_nget_err", {31'b0, e}, 32'd1);
        check("rst_mid_nget_dat", d, 32'd0);

`ifdef AEMB_FSL_TIMEOUT_EN
        start(1'b0, 2'b00, 5'd0, 32'h0);
        wait_ack(TMO + 3, 1'b0, got, lat, d, e);
        check("tmo_ack", {31'b0, got}, 32'd1);
        check("tmo_err", {31'b0, e}, 32'd1);
        check("tmo_dat", d, 32'd0);
`endif

        repeat (3) @(negedge gclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
